param_lifo_stack: RTL and testbench

- Parametrised synchronous LIFO stack. It is the next-generation storage block for the tt06 stack designs.
- Generalises the fixed 8-bit × 32 stack to configurable width and depth.
- Adds:
  - a valid/ready command handshake
  - a registered pop response
  - atomic replace-top (push+pop)
  - flush
  - sticky overflow/underflow error flags
- Sits between the top-level pin wrapper and the user logic. The wrapper maps pins onto push/pop/wdata and presents rdata/status.

---
 rtl/param_lifo_stack.sv | 83 ++++++++
 tb/tb_param_lifo_stack.sv | 109 ++++++++++
 2 files changed

// File: rtl/param_lifo_stack.sv
// param_lifo_stack: parametrised LIFO stack with handshake, registered pop response and sticky errors
// Optional macro: PARAM_LIFO_STACK_HWM_EN enables high-water-mark tracking on hwm (else hwm is 0).
// Ports: clk/rst_n (async active-low) | push, pop, wdata, flush, err_clr in
//        ready, rdata, rdata_valid, count, empty, full, overflow, underflow, hwm out
module param_lifo_stack #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 32,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   input  logic              flush,
   input  logic              err_clr,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow,
   output logic [PTR_W:0]    hwm
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [0:0]        r_state;
   logic [PTR_W:0]    r_count;
   logic              r_ovf, r_udf;
   logic              w_cmd, w_empty, w_full;
   logic              w_push_ok, w_pop_ok, w_repl, w_push_empty, w_ovf, w_udf, w_wr;
   logic [PTR_W-1:0]  w_top, w_waddr;
   assign w_empty      = r_count == '0;
   assign w_full       = r_count == (PTR_W+1)'(DEPTH);
   // commands are only honoured in IDLE and are dropped by flush
   assign w_cmd        = (r_state == S_IDLE) & ~flush;
   assign w_push_ok    = w_cmd & push & ~pop & ~w_full;
   assign w_ovf        = w_cmd & push & ~pop & w_full;
   assign w_pop_ok     = w_cmd & pop & ~push & ~w_empty;
   assign w_repl       = w_cmd & push & pop & ~w_empty;
   assign w_push_empty = w_cmd & push & pop & w_empty;
   assign w_udf        = w_cmd & pop & w_empty;
   assign w_top        = r_count[PTR_W-1:0] - 1'b1;
   assign w_waddr      = w_repl ? w_top : r_count[PTR_W-1:0];
   // gate with rst_n so no write lands on an edge while reset is held
   assign w_wr         = rst_n & (w_push_ok | w_push_empty | w_repl);
   always_ff @(posedge clk)
      if (w_wr) r_mem[w_waddr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_count <= '0;
         rdata   <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_state <= flush ? S_IDLE : (w_pop_ok | w_repl) ? S_RESP : S_IDLE;
         r_count <= flush ? '0 : (w_push_ok | w_push_empty) ? r_count + 1'b1 :
                    w_pop_ok ? r_count - 1'b1 : r_count;
         if (w_pop_ok | w_repl) rdata <= r_mem[w_top];
         r_ovf   <= w_ovf | (r_ovf & ~err_clr);
         r_udf   <= w_udf | (r_udf & ~err_clr);
      end
`ifdef PARAM_LIFO_STACK_HWM_EN
   logic [PTR_W:0] r_hwm;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_hwm <= '0;
      else        r_hwm <= err_clr ? r_count : (r_count > r_hwm) ? r_count : r_hwm;
   assign hwm = r_hwm;
`else
   assign hwm = '0;
`endif
   assign ready       = r_state == S_IDLE;
   assign rdata_valid = r_state == S_RESP;
   assign count       = r_count;
   assign empty       = w_empty;
   assign full        = w_full;
   assign overflow    = r_ovf;
   assign underflow   = r_udf;
endmodule

// File: tb/tb_param_lifo_stack.sv
// tb_param_lifo_stack: random and directed stimulus against a queue-based stack model
module tb_param_lifo_stack;
   localparam int DW  = 8;
   localparam int DEP = 4;
   localparam int PW  = 2;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic          push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          ready, rdata_valid, empty, full, overflow, underflow;
   logic [DW-1:0] rdata;
   logic [PW:0]   count, hwm;
   int            checks = 0, errors = 0;
   logic [DW-1:0] q[$];
   bit            m_busy, m_ovf, m_udf;
   logic [DW-1:0] m_rdata;
   int            m_hwm;
   param_lifo_stack #(.DATA_W(DW), .DEPTH(DEP)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(wdata), .flush(flush),
      .err_clr(err_clr), .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid),
      .count(count), .empty(empty), .full(full), .overflow(overflow),
      .underflow(underflow), .hwm(hwm)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask
   task automatic check_all;
      check("count", 32'(count), q.size());
      check("empty", 32'(empty), q.size() == 0);
      check("full", 32'(full), q.size() == DEP);
      check("ready", 32'(ready), !m_busy);
      check("rdata_valid", 32'(rdata_valid), m_busy);
      check("rdata", 32'(rdata), 32'(m_rdata));
      check("overflow", 32'(overflow), m_ovf);
      check("underflow", 32'(underflow), m_udf);
`ifdef PARAM_LIFO_STACK_HWM_EN
      check("hwm", 32'(hwm), m_hwm);
`else
      check("hwm", 32'(hwm), 0);
`endif
   endtask
   task automatic model_reset;
      q.delete();
      m_busy = 0; m_ovf = 0; m_udf = 0; m_rdata = '0; m_hwm = 0;
   endtask
   // asynchronous reset applied mid-cycle, checked before any clock edge
   task automatic do_reset;
      rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic step(input bit pu, input bit po, input logic [DW-1:0] wd, input bit fl, input bit ec);
      int n;
      @(negedge clk);
      push = pu; pop = po; wdata = wd; flush = fl; err_clr = ec;
      n = q.size();
      if (ec) begin m_ovf = 0; m_udf = 0; end
      if (fl) begin q.delete(); m_busy = 0; end
      else if (m_busy) m_busy = 0;
      else if (pu && !po) begin
         if (n == DEP) m_ovf = 1; else q.push_back(wd);
      end else if (po && !pu) begin
         if (n == 0) m_udf = 1;
         else begin m_rdata = q.pop_back(); m_busy = 1; end
      end else if (pu && po) begin
         if (n == 0) begin m_udf = 1; q.push_back(wd); end
         else begin m_rdata = q[n-1]; q[n-1] = wd; m_busy = 1; end
      end
      m_hwm = ec ? n : (n > m_hwm ? n : m_hwm);
      @(posedge clk);
      #1 check_all();
      push = 0; pop = 0; flush = 0; err_clr = 0;
   endtask
   initial begin
      model_reset();
      #3 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 8'h11, 0, 0); step(1, 0, 8'h22, 0, 0);
      step(1, 0, 8'h33, 0, 0); step(1, 0, 8'h44, 0, 0);
      step(1, 0, 8'h55, 0, 0);
      for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end
      step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 1); step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(1, 0, 8'hA0, 0, 0); step(1, 0, 8'hB0, 0, 0);
      step(1, 1, 8'hC0, 0, 0); step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
      step(1, 0, 8'h01, 0, 0); step(1, 0, 8'h02, 0, 0); step(1, 0, 8'h03, 0, 0);
      step(1, 0, 8'h04, 1, 0); step(0, 1, 0, 0, 0);
      step(1, 1, 8'h5A, 0, 1);
      step(1, 0, 8'h06, 0, 0); step(0, 1, 0, 0, 0);
      do_reset();
      step(1, 0, 8'h07, 0, 0); step(1, 0, 8'h08, 0, 0); step(1, 0, 8'h09, 0, 0);
      step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 2) do_reset();
         else step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40, DW'($urandom),
                   $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
